// File: rtl/memoria_dmulc_core.sv
// -----------------------------------------------------------------------------
// memoria_dmulc_core
// Three independent 2**ADDR_W x DATA_W register banks (B1, B2, B3). Each bank
// has one synchronous port with a registered read. A bank-to-bank copy command
// moves a whole bank in a single clock edge.
//
// Ports
//   i_clk                   rising-edge clock
//   i_rst_n                 synchronous active-low reset; clears banks and read data
//   i_add1/2/3  [ADDR_W]    address, port n -> bank Bn
//   i_dat1/2/3  [DATA_W]    write data, port n
//   i_w1/2/3                write enable, port n
//   i_r1/2/3                read enable, port n (read data appears one cycle later)
//   i_flags     [3]         copy command: 001 B2->B1, 010 B1->B2, 011 B3->B1,
//                           100 B1->B3, 101 B3->B2, 110 B2->B3, 000/111 none
//   o_dato1/2/3 [DATA_W]    registered read data, port n; holds when not reading
// -----------------------------------------------------------------------------
module memoria_dmulc_core #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [ADDR_W-1:0] i_add1,
   input  logic [ADDR_W-1:0] i_add2,
   input  logic [ADDR_W-1:0] i_add3,
   input  logic [DATA_W-1:0] i_dat1,
   input  logic [DATA_W-1:0] i_dat2,
   input  logic [DATA_W-1:0] i_dat3,
   input  logic [2:0]        i_flags,
   input  logic              i_w1,
   input  logic              i_w2,
   input  logic              i_w3,
   input  logic              i_r1,
   input  logic              i_r2,
   input  logic              i_r3,
   output logic [DATA_W-1:0] o_dato1,
   output logic [DATA_W-1:0] o_dato2,
   output logic [DATA_W-1:0] o_dato3
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_b1 [DEPTH];
   logic [DATA_W-1:0] r_b2 [DEPTH];
   logic [DATA_W-1:0] r_b3 [DEPTH];

   logic [DATA_W-1:0] r_dato1;
   logic [DATA_W-1:0] r_dato2;
   logic [DATA_W-1:0] r_dato3;

   // Copy decode: which bank is overwritten this edge, and from where
   logic w_cp_b1;      // B1 is destination
   logic w_cp_b2;      // B2 is destination
   logic w_cp_b3;      // B3 is destination
   logic w_b1_from_b3; // B1 source: 1 = B3, 0 = B2
   logic w_b2_from_b3; // B2 source: 1 = B3, 0 = B1
   logic w_b3_from_b2; // B3 source: 1 = B2, 0 = B1

   always_comb begin
      w_cp_b1      = 1'b0;
      w_cp_b2      = 1'b0;
      w_cp_b3      = 1'b0;
      w_b1_from_b3 = 1'b0;
      w_b2_from_b3 = 1'b0;
      w_b3_from_b2 = 1'b0;
      case (i_flags)
         3'b001: w_cp_b1 = 1'b1;
         3'b010: w_cp_b2 = 1'b1;
         3'b011: begin
            w_cp_b1      = 1'b1;
            w_b1_from_b3 = 1'b1;
         end
         3'b100: w_cp_b3 = 1'b1;
         3'b101: begin
            w_cp_b2      = 1'b1;
            w_b2_from_b3 = 1'b1;
         end
         3'b110: begin
            w_cp_b3      = 1'b1;
            w_b3_from_b2 = 1'b1;
         end
         default: ;
      endcase
   end

   // Bank storage: reset > copy into destination > port write.
   // Non-blocking reads of r_bN give pre-edge sources for copies and reads.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_b1[i] <= '0;
            r_b2[i] <= '0;
            r_b3[i] <= '0;
         end
      end else begin
         if (w_cp_b1) begin
            for (int unsigned i = 0; i < DEPTH; i++)
               r_b1[i] <= w_b1_from_b3 ? r_b3[i] : r_b2[i];
         end else if (i_w1) begin
            r_b1[i_add1] <= i_dat1;
         end

         if (w_cp_b2) begin
            for (int unsigned i = 0; i < DEPTH; i++)
               r_b2[i] <= w_b2_from_b3 ? r_b3[i] : r_b1[i];
         end else if (i_w2) begin
            r_b2[i_add2] <= i_dat2;
         end

         if (w_cp_b3) begin
            for (int unsigned i = 0; i < DEPTH; i++)
               r_b3[i] <= w_b3_from_b2 ? r_b2[i] : r_b1[i];
         end else if (i_w3) begin
            r_b3[i_add3] <= i_dat3;
         end
      end
   end

   // Registered reads; old word returned on read-during-write or copy
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_dato1 <= '0;
         r_dato2 <= '0;
         r_dato3 <= '0;
      end else begin
         if (i_r1) r_dato1 <= r_b1[i_add1];
         if (i_r2) r_dato2 <= r_b2[i_add2];
         if (i_r3) r_dato3 <= r_b3[i_add3];
      end
   end

   assign o_dato1 = r_dato1;
   assign o_dato2 = r_dato2;
   assign o_dato3 = r_dato3;

endmodule

// File: tb/tb_memoria_dmulc_core.sv
// -----------------------------------------------------------------------------
// tb_memoria_dmulc_core
// Directed bench for memoria_dmulc_core: reset, per-port write/read, all copy
// codes, copy/write priority, read-during-write and reset during activity.
// -----------------------------------------------------------------------------
module tb_memoria_dmulc_core;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] add1, add2, add3;
   logic [DW-1:0] dat1, dat2, dat3;
   logic [2:0]    flags;
   logic          w1, w2, w3, r1, r2, r3;
   logic [DW-1:0] dato1, dato2, dato3;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   memoria_dmulc_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_add1  (add1),
      .i_add2  (add2),
      .i_add3  (add3),
      .i_dat1  (dat1),
      .i_dat2  (dat2),
      .i_dat3  (dat3),
      .i_flags (flags),
      .i_w1    (w1),
      .i_w2    (w2),
      .i_w3    (w3),
      .i_r1    (r1),
      .i_r2    (r2),
      .i_r3    (r3),
      .o_dato1 (dato1),
      .o_dato2 (dato2),
      .o_dato3 (dato3)
   );

   // Inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      w1 = 1'b0; w2 = 1'b0; w3 = 1'b0;
      r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
      flags = 3'b000;
   endtask

   task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                     input logic [AW-1:0] a3);
      idle();
      add1 = a1; add2 = a2; add3 = a3;
      r1 = 1'b1; r2 = 1'b1; r3 = 1'b1;
      tick();
      idle();
   endtask

   task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
      idle();
      case (port)
         1: begin add1 = a; dat1 = d; w1 = 1'b1; end
         2: begin add2 = a; dat2 = d; w2 = 1'b1; end
         default: begin add3 = a; dat3 = d; w3 = 1'b1; end
      endcase
      tick();
      idle();
   endtask

   task automatic copy(input logic [2:0] code, input int cycles);
      idle();
      flags = code;
      repeat (cycles) tick();
      idle();
   endtask

   task automatic test_reset();
      // Reset overrides a write, a copy and reads on the same edge
      rst_n = 1'b0;
      add1 = 4'd3; add2 = 4'd3; add3 = 4'd3;
      dat1 = 8'hAA; dat2 = 8'hBB; dat3 = 8'hCC;
      w1 = 1'b1; w2 = 1'b0; w3 = 1'b0;
      r1 = 1'b1; r2 = 1'b1; r3 = 1'b1;
      flags = 3'b001;
      tick();
      tick();
      n_total += 3;
      if (dato1 !== 8'h00) $display("FAIL reset_dato1 got=%h exp=00", dato1); else n_pass++;
      if (dato2 !== 8'h00) $display("FAIL reset_dato2 got=%h exp=00", dato2); else n_pass++;
      if (dato3 !== 8'h00) $display("FAIL reset_dato3 got=%h exp=00", dato3); else n_pass++;
      rst_n = 1'b1;
      idle();
      for (int i = 0; i < 16; i++) begin
         rd(AW'(i), AW'(i), AW'(i));
         n_total += 3;
         if (dato1 !== 8'h00) $display("FAIL reset_b1 addr=%0d got=%h exp=00", i, dato1); else n_pass++;
         if (dato2 !== 8'h00) $display("FAIL reset_b2 addr=%0d got=%h exp=00", i, dato2); else n_pass++;
         if (dato3 !== 8'h00) $display("FAIL reset_b3 addr=%0d got=%h exp=00", i, dato3); else n_pass++;
      end
   endtask

   task automatic test_write_read();
      for (int i = 0; i < 15; i++) wr(1, AW'(i), DW'(i));
      for (int i = 0; i < 15; i++) begin
         rd(AW'(i), AW'(i), AW'(i));
         n_total += 2;
         if (dato1 !== DW'(i)) $display("FAIL wr_b1 addr=%0d got=%h exp=%h", i, dato1, DW'(i)); else n_pass++;
         if (dato2 !== 8'h00) $display("FAIL wr_b2_isolated addr=%0d got=%h exp=00", i, dato2); else n_pass++;
      end
      // Read enable low: output holds the last read word (B1[14])
      idle();
      add1 = 4'd2;
      tick();
      n_total++;
      if (dato1 !== 8'd14) $display("FAIL read_hold got=%h exp=0e", dato1); else n_pass++;
      // Read and write same address same edge returns the old word
      idle();
      add1 = 4'd5; dat1 = 8'h77; w1 = 1'b1; r1 = 1'b1;
      tick();
      idle();
      n_total++;
      if (dato1 !== 8'h05) $display("FAIL rdw_old got=%h exp=05", dato1); else n_pass++;
      rd(4'd5, 4'd0, 4'd0);
      n_total++;
      if (dato1 !== 8'h77) $display("FAIL rdw_new got=%h exp=77", dato1); else n_pass++;
      wr(1, 4'd5, 8'h05);
   endtask

   task automatic test_copy_b1_to_b2();
      for (int i = 0; i < 15; i++) wr(2, AW'(i), DW'(15 - i));
      for (int i = 0; i < 15; i++) begin
         rd(AW'(i), AW'(i), AW'(i));
         n_total += 2;
         if (dato2 !== DW'(15 - i)) $display("FAIL b2_fill addr=%0d got=%h exp=%h", i, dato2, DW'(15 - i)); else n_pass++;
         if (dato1 !== DW'(i)) $display("FAIL b1_intact addr=%0d got=%h exp=%h", i, dato1, DW'(i)); else n_pass++;
      end
      copy(3'b010, 1);
      for (int i = 0; i < 16; i++) begin
         rd(AW'(i), AW'(i), AW'(i));
         n_total++;
         // B1[15] was never written, so B2[15] becomes 0
         if (dato2 !== ((i < 15) ? DW'(i) : 8'h00))
            $display("FAIL copy_010 addr=%0d got=%h exp=%h", i, dato2, (i < 15) ? DW'(i) : 8'h00);
         else n_pass++;
      end
   endtask

   task automatic test_copy_b2_to_b1();
      for (int i = 0; i < 15; i++) wr(2, AW'(i), 8'h34);
      copy(3'b001, 2); // held two edges: same result
      for (int i = 0; i < 16; i++) begin
         rd(AW'(i), AW'(i), AW'(i));
         n_total += 2;
         if (dato1 !== ((i < 15) ? 8'h34 : 8'h00))
            $display("FAIL copy_001 addr=%0d got=%h exp=%h", i, dato1, (i < 15) ? 8'h34 : 8'h00);
         else n_pass++;
         if (dato3 !== 8'h00) $display("FAIL copy_001_b3 addr=%0d got=%h exp=00", i, dato3); else n_pass++;
      end
   endtask

   task automatic test_copy_priority();
      // Write to destination loses to the copy
      idle();
      add1 = 4'd3; dat1 = 8'hAA; w1 = 1'b1; flags = 3'b001;
      tick();
      rd(4'd3, 4'd3, 4'd3);
      n_total++;
      if (dato1 !== 8'h34) $display("FAIL copy_beats_write got=%h exp=34", dato1); else n_pass++;
      // Source write not copied, other bank write proceeds, read sees pre-copy data
      wr(1, 4'd4, 8'h11);
      idle();
      flags = 3'b001;
      add2 = 4'd3; dat2 = 8'h55; w2 = 1'b1;
      add3 = 4'd7; dat3 = 8'h99; w3 = 1'b1;
      add1 = 4'd4; r1 = 1'b1;
      tick();
      idle();
      n_total++;
      if (dato1 !== 8'h11) $display("FAIL read_precopy got=%h exp=11", dato1); else n_pass++;
      rd(4'd3, 4'd3, 4'd7);
      n_total += 3;
      if (dato1 !== 8'h34) $display("FAIL copy_old_src got=%h exp=34", dato1); else n_pass++;
      if (dato2 !== 8'h55) $display("FAIL src_write got=%h exp=55", dato2); else n_pass++;
      if (dato3 !== 8'h99) $display("FAIL other_write got=%h exp=99", dato3); else n_pass++;
      rd(4'd4, 4'd0, 4'd0);
      n_total++;
      if (dato1 !== 8'h34) $display("FAIL copy_overwrite got=%h exp=34", dato1); else n_pass++;
   endtask

   task automatic test_other_copies();
      // B3: [0]=80 [7]=87 [15]=8f, rest 0
      wr(3, 4'd0, 8'h80);
      wr(3, 4'd7, 8'h87);
      wr(3, 4'd15, 8'h8F);
      // 101: B3 -> B2 while a B1 write proceeds
      idle();
      flags = 3'b101;
      add1 = 4'd2; dat1 = 8'hC3; w1 = 1'b1;
      tick();
      idle();
      rd(4'd2, 4'd7, 4'd0);
      n_total += 2;
      if (dato1 !== 8'hC3) $display("FAIL copy_101_b1w got=%h exp=c3", dato1); else n_pass++;
      if (dato2 !== 8'h87) $display("FAIL copy_101_a7 got=%h exp=87", dato2); else n_pass++;
      rd(4'd0, 4'd15, 4'd0);
      n_total++;
      if (dato2 !== 8'h8F) $display("FAIL copy_101_a15 got=%h exp=8f", dato2); else n_pass++;
      rd(4'd0, 4'd2, 4'd0);
      n_total++;
      if (dato2 !== 8'h00) $display("FAIL copy_101_a2 got=%h exp=00", dato2); else n_pass++;
      // 011: B3 -> B1
      copy(3'b011, 1);
      rd(4'd7, 4'd0, 4'd0);
      n_total++;
      if (dato1 !== 8'h87) $display("FAIL copy_011_a7 got=%h exp=87", dato1); else n_pass++;
      rd(4'd2, 4'd0, 4'd0);
      n_total++;
      if (dato1 !== 8'h00) $display("FAIL copy_011_a2 got=%h exp=00", dato1); else n_pass++;
      // 100: B1 -> B3
      wr(1, 4'd7, 8'h47);
      wr(1, 4'd2, 8'h42);
      copy(3'b100, 1);
      rd(4'd0, 4'd0, 4'd7);
      n_total++;
      if (dato3 !== 8'h47) $display("FAIL copy_100_a7 got=%h exp=47", dato3); else n_pass++;
      rd(4'd0, 4'd0, 4'd0);
      n_total++;
      if (dato3 !== 8'h80) $display("FAIL copy_100_a0 got=%h exp=80", dato3); else n_pass++;
      rd(4'd0, 4'd0, 4'd2);
      n_total++;
      if (dato3 !== 8'h42) $display("FAIL copy_100_a2 got=%h exp=42", dato3); else n_pass++;
      // 110: B2 -> B3
      copy(3'b110, 1);
      rd(4'd0, 4'd0, 4'd7);
      n_total++;
      if (dato3 !== 8'h87) $display("FAIL copy_110_a7 got=%h exp=87", dato3); else n_pass++;
      rd(4'd0, 4'd0, 4'd2);
      n_total++;
      if (dato3 !== 8'h00) $display("FAIL copy_110_a2 got=%h exp=00", dato3); else n_pass++;
      // 111: reserved, nothing moves
      copy(3'b111, 2);
      rd(4'd7, 4'd7, 4'd7);
      n_total += 3;
      if (dato1 !== 8'h47) $display("FAIL nop_111_b1 got=%h exp=47", dato1); else n_pass++;
      if (dato2 !== 8'h87) $display("FAIL nop_111_b2 got=%h exp=87", dato2); else n_pass++;
      if (dato3 !== 8'h87) $display("FAIL nop_111_b3 got=%h exp=87", dato3); else n_pass++;
   endtask

   task automatic test_reset_mid();
      idle();
      rst_n = 1'b0;
      flags = 3'b001;
      add1 = 4'd1; dat1 = 8'hFF; w1 = 1'b1;
      add2 = 4'd7; add3 = 4'd7;
      r1 = 1'b1; r2 = 1'b1; r3 = 1'b1;
      tick();
      rst_n = 1'b1;
      idle();
      n_total += 3;
      if (dato1 !== 8'h00) $display("FAIL midrst_dato1 got=%h exp=00", dato1); else n_pass++;
      if (dato2 !== 8'h00) $display("FAIL midrst_dato2 got=%h exp=00", dato2); else n_pass++;
      if (dato3 !== 8'h00) $display("FAIL midrst_dato3 got=%h exp=00", dato3); else n_pass++;
      for (int i = 0; i < 16; i++) begin
         rd(AW'(i), AW'(i), AW'(i));
         n_total += 3;
         if (dato1 !== 8'h00) $display("FAIL midrst_b1 addr=%0d got=%h exp=00", i, dato1); else n_pass++;
         if (dato2 !== 8'h00) $display("FAIL midrst_b2 addr=%0d got=%h exp=00", i, dato2); else n_pass++;
         if (dato3 !== 8'h00) $display("FAIL midrst_b3 addr=%0d got=%h exp=00", i, dato3); else n_pass++;
      end
      // Normal operation resumes right away
      wr(1, 4'd0, 8'h5A);
      rd(4'd0, 4'd0, 4'd0);
      n_total++;
      if (dato1 !== 8'h5A) $display("FAIL resume got=%h exp=5a", dato1); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      add1 = '0; add2 = '0; add3 = '0;
      dat1 = '0; dat2 = '0; dat3 = '0;
      idle();
      test_reset();
      test_write_read();
      test_copy_b1_to_b2();
      test_copy_b2_to_b1();
      test_copy_priority();
      test_other_copies();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/memoria_dmulc_core.md
MEMORIA_DMULC_CORE -- requirements
Module: memoria_dmulc

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, word width of every bank and data port.
REQ-002 SHALL provide parameter ADDR_W, default 4, address width; bank depth is 2**ADDR_W (16).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on rising clk.
REQ-005 ADD1, ADD2, ADD3  input  ADDR_W each  address for port 1/2/3.
REQ-006 DAT1, DAT2, DAT3  input  DATA_W each  write data for port 1/2/3.
REQ-007 Dato1, Dato2, Dato3  output  DATA_W each  registered read data for port 1/2/3.
REQ-008 flags  input  3  bank-copy command; only bits [2:0] are significant.
REQ-009 w1, w2, w3  input  1 each  write enable, port 1/2/3.
REQ-010 r1, r2, r3  input  1 each  read enable, port 1/2/3.

Function
REQ-011 SHALL contain three independent banks B1, B2, B3; each is 16 x DATA_W; port n accesses only bank Bn.
REQ-012 Write: on rising clk, if wn=1, Bn[ADDn] <= DATn; takes effect the same edge.
REQ-013 Read: on rising clk, if rn=1, Daton <= Bn[ADDn] (1-cycle latency); if rn=0, Daton holds its value.
REQ-014 Read and write on the same port, same edge, same address SHALL return the old (pre-write) word.
REQ-015 Ports 1-3 operate concurrently; there are no cross-port conflicts outside copy commands.
REQ-016 Copy: on rising clk, the flags value SHALL copy all 16 words of the source bank into the destination bank in that single edge.
- 000: no operation
- 001: B2 -> B1
- 010: B1 -> B2
- 011: B3 -> B1
- 100: B1 -> B3
- 101: B3 -> B2
- 110: B2 -> B3
- 111: no operation (reserved)
REQ-017 The copy SHALL use source contents from before the edge; any write to the source bank on that edge is not copied.
REQ-018 On a copy edge, copy SHALL take priority over any write to the destination bank; writes to the other two banks proceed normally.
REQ-019 Reads on a copy edge SHALL return pre-copy contents.
REQ-020 flags is level-sensitive: the copy repeats on every edge while the non-zero code is held, with identical result.
REQ-021 No handshake and no busy/ready signalling; every operation completes in one cycle.

Reset
REQ-022 While reset=0 at a rising edge, all 48 words of B1-B3 SHALL clear to 0 and Dato1-Dato3 SHALL clear to 0.
REQ-023 Reset SHALL override writes, reads and copies on the same edge.
REQ-024 Reset asserted mid-sequence SHALL discard any in-progress activity; normal operation resumes on the first edge with reset=1.
REQ-025 Bank contents after power-up without reset are unspecified; the bench SHALL apply reset first.

Verification
REQ-026 Reset, then r1=r2=r3=1 at addresses 0..15 -> Dato1-Dato3 = 0 at every address.
REQ-027 Write B1[i]=i for i=0..14 via w1; read port 1 at i -> Dato1=i one cycle later; port 2 at i -> Dato2=0.
REQ-028 Write B2[i]=15-i via w2 -> port 2 reads 15-i and port 1 still reads i; flags=010 for one cycle -> port 2 reads i for i=0..14.
REQ-029 Fill B2 with 52 (0x34) for i=0..14, then flags=001 for one cycle -> port 1 reads 52 at i=0..14; port 3 reads 0.
REQ-030 Same edge: w1=1, ADD1=3, DAT1=0xAA, with flags=001 -> B1[3]=B2[3] (copy wins); same edge w2=1 to B2[3] -> B1[3] gets the old B2[3].
REQ-031 Banks populated, then reset=0 for one edge with flags=001 and w1=1 -> all reads return 0 afterwards; Dato1-Dato3 read 0 immediately after reset.
